hazard_forward_unit: RTL

Parametrised successor to the combinational EX-stage forwarding logic. It tracks in-flight register writers in a shadow pipeline and pre-computes registered forwarding selects at the ID/EX boundary. It detects load-use hazards and long-latency (mul/div) RAW/WAW hazards, and counts stall cycles. It sits beside the ID/EX pipeline register and drives the EX operand forwarding muxes and the ID stall line.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/hazard_scoreboard.sv | 39 +++
 rtl/hazard_forward_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the hazard/forwarding logic.
// Producer kinds, the shadow-pipeline entry and the fwd_sel width helper.
package rv32i_types;

   typedef enum logic [1:0] {
      PK_ALU  = 2'd0,
      PK_LOAD = 2'd1,
      PK_LONG = 2'd2
   } prod_kind_t;

   // rd is stored zero-extended so one entry type serves any REG_ADDR_W
   localparam int RD_W_MAX = 8;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                we;
      prod_kind_t          kind;
   } shadow_ent_t;

   function automatic int fwd_sel_w(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy bits for long-latency destinations, with release bypass.
// Ports: clr_en/clr_rd release, set_en/set_rd claim, busy_vec, busy_eff.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_rd,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic [NUM_REGS-1:0]   busy_eff
);

   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (clr_en)
         clr_mask[clr_rd] = 1'b1;
      if (set_en && set_rd != '0)
         set_mask[set_rd] = 1'b1;
   end

   // a register written back this cycle is no longer a hazard
   assign busy_eff = busy_vec & ~clr_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_vec <= '0;
      else
         busy_vec <= busy_eff | set_mask;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow-pipeline hazard detection and registered forwarding selects.
// Ports: issue_* from ID, advance/flush control, long_* writeback, stall/fwd_sel/busy_vec/stall_count out.
module hazard_forward_unit
   import rv32i_types::*;
#(
   parameter  int NUM_SRC        = 2,
   parameter  int NUM_FWD_STAGES = 2,
   parameter  int REG_ADDR_W     = 5,
   parameter  int NUM_REGS       = 32,
   localparam int SEL_W          = fwd_sel_w(NUM_FWD_STAGES)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                advance,
   input  logic                                flush,
   input  logic                                issue_valid,
   input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  issue_rs,
   input  logic [NUM_SRC-1:0]                  issue_rs_used,
   input  logic [REG_ADDR_W-1:0]               issue_rd,
   input  logic                                issue_we,
   input  prod_kind_t                          issue_kind,
   input  logic                                long_done,
   input  logic [REG_ADDR_W-1:0]               long_rd,
   output logic                                stall,
   output logic [NUM_SRC-1:0][SEL_W-1:0]       fwd_sel,
   output logic [NUM_REGS-1:0]                 busy_vec,
   output logic [31:0]                         stall_count
);

   shadow_ent_t                   shadow_q [NUM_FWD_STAGES];
   shadow_ent_t                   new_ent;
   logic [NUM_SRC-1:0][SEL_W-1:0] next_sel;
   logic [NUM_REGS-1:0]           busy_eff;
   logic [NUM_SRC-1:0]            lu_hit;
   logic [NUM_SRC-1:0]            raw_hit;
   logic                          waw_hit;
   logic                          accepted;

   hazard_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_REGS   (NUM_REGS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .clr_en   (long_done),
      .clr_rd   (long_rd),
      .set_en   (advance && accepted && issue_kind == PK_LONG),
      .set_rd   (issue_rd),
      .busy_vec (busy_vec),
      .busy_eff (busy_eff)
   );

   // scan oldest to youngest so the youngest match is the last write
   always_comb begin
      next_sel = '0;
      lu_hit   = '0;
      raw_hit  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (issue_rs_used[i] && issue_rs[i] != '0) begin
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
               if (shadow_q[k].valid && shadow_q[k].we &&
                   shadow_q[k].rd == RD_W_MAX'(issue_rs[i])) begin
                  next_sel[i] = SEL_W'(k + 1);
                  lu_hit[i]   = (k == 0) && (shadow_q[k].kind == PK_LOAD);
               end
            end
            raw_hit[i] = busy_eff[issue_rs[i]];
         end
      end
   end

   assign waw_hit  = (issue_kind == PK_LONG) && busy_eff[issue_rd];
   assign stall    = issue_valid && !flush &&
                     ((|lu_hit) || (|raw_hit) || waw_hit);
   assign accepted = issue_valid && !stall && !flush;

   // long ops write through the scoreboard, never through the bypass
   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.rd    = RD_W_MAX'(issue_rd);
      new_ent.we    = issue_we && (issue_kind != PK_LONG);
      new_ent.kind  = issue_kind;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_FWD_STAGES; k++)
            shadow_q[k] <= '0;
         fwd_sel     <= '0;
         stall_count <= '0;
      end else if (advance) begin
         for (int k = 1; k < NUM_FWD_STAGES; k++)
            shadow_q[k] <= shadow_q[k-1];
         shadow_q[0] <= accepted ? new_ent : '0;
         fwd_sel     <= accepted ? next_sel : '0;
         if (stall && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
      end
   end

endmodule
